// File: rtl/div16u8_pkg.sv
// -----------------------------------------------------------------------------
// div16u8_pkg
// Shared types and constants for the sequential unsigned 16/8 divider.
//   state_t    : controller states (IDLE, BUSY, DONE)
//   DIVIDEND_W : dividend width (16)
//   DIVISOR_W  : divisor / quotient / remainder width (8)
//   STEPS      : restoring steps per division (one quotient bit each)
//   CNT_W      : width of the step counter
//   QSAT       : saturated quotient used for divide-by-zero and overflow
// -----------------------------------------------------------------------------
package div16u8_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIVIDEND_W = 16;
   localparam int DIVISOR_W  = 8;
   localparam int STEPS      = 8;
   localparam int CNT_W      = $clog2(STEPS);

   localparam logic [DIVISOR_W-1:0] QSAT = 8'hFF;

endpackage

// File: rtl/div16u8_step.sv
// -----------------------------------------------------------------------------
// div16u8_step
// Combinational single radix-2 restoring division step.
// Ports:
//   r       in  [7:0] current partial remainder (always < divisor)
//   q_msb   in        next dividend bit shifted into the remainder
//   divisor in  [7:0] divisor
//   r_next  out [8:0] partial remainder after this step
//   qbit    out       quotient bit produced by this step
// -----------------------------------------------------------------------------
module div16u8_step
   import div16u8_pkg::*;
(
   input  logic [DIVISOR_W-1:0] r,
   input  logic                 q_msb,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W:0]   r_next,
   output logic                 qbit
);

   logic [DIVISOR_W:0] t;
   logic [DIVISOR_W:0] d_ext;

   // r < divisor on entry, so t <= 2*divisor-1 and 9 bits are enough.
   assign t     = {r, q_msb};
   assign d_ext = {1'b0, divisor};

   always_comb begin
      r_next = t;
      qbit   = 1'b0;
      if (t >= d_ext) begin
         r_next = t - d_ext;
         qbit   = 1'b1;
      end
   end

endmodule

// File: rtl/div16u8_seq_wrapper.sv
// -----------------------------------------------------------------------------
// div16u8_seq_wrapper
// Sequential unsigned 16-by-8 restoring divider, one quotient bit per cycle,
// with valid/ready handshakes on both sides.
// Ports:
//   clk         in        clock, rising edge
//   rst         in        asynchronous active-high reset
//   in_valid    in        operands valid
//   in_ready    out       ready to accept operands (state IDLE)
//   dividend    in  [15:0] unsigned dividend
//   divisor     in  [7:0]  unsigned divisor
//   out_valid   out       result valid, held until out_ready
//   out_ready   in        consumer accepts result
//   quotient    out [7:0] unsigned quotient (FF when saturated)
//   remainder   out [7:0] unsigned remainder
//   overflow    out       quotient would not fit in 8 bits
//   div_by_zero out       divisor was zero
// -----------------------------------------------------------------------------
module div16u8_seq_wrapper
   import div16u8_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVISOR_W-1:0]  quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  overflow,
   output logic                  div_by_zero
);

   state_t                 state_q;
   logic [DIVISOR_W-1:0]   r_q;
   logic [DIVISOR_W-1:0]   q_q;
   logic [DIVISOR_W-1:0]   divisor_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   ovf_pend_q;
   logic                   dbz_pend_q;

   logic                   out_valid_q;
   logic [DIVISOR_W-1:0]   quotient_q;
   logic [DIVISOR_W-1:0]   remainder_q;
   logic                   overflow_q;
   logic                   div_by_zero_q;

   logic [DIVISOR_W:0]     step_r_next;
   logic                   step_qbit;
   logic                   step_r_msb_unused;
   logic [DIVISOR_W-1:0]   q_d;

   div16u8_step u_step (
      .r       (r_q),
      .q_msb   (q_q[DIVISOR_W-1]),
      .divisor (divisor_q),
      .r_next  (step_r_next),
      .qbit    (step_qbit)
   );

   // The partial remainder stays below the divisor, so bit 8 of the step
   // result is always zero and only the low byte is kept.
   assign step_r_msb_unused = step_r_next[DIVISOR_W];

   assign q_d = {q_q[DIVISOR_W-2:0], step_qbit};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         r_q           <= '0;
         q_q           <= '0;
         divisor_q     <= '0;
         cnt_q         <= '0;
         ovf_pend_q    <= 1'b0;
         dbz_pend_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         overflow_q    <= 1'b0;
         div_by_zero_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  divisor_q  <= divisor;
                  r_q        <= dividend[DIVIDEND_W-1:DIVISOR_W];
                  q_q        <= dividend[DIVISOR_W-1:0];
                  cnt_q      <= '0;
                  dbz_pend_q <= (divisor == '0);
                  ovf_pend_q <= (divisor != '0) &&
                                (dividend[DIVIDEND_W-1:DIVISOR_W] >= divisor);
                  state_q    <= BUSY;
               end
            end

            BUSY: begin
               // Saturated cases are classified at accept time and published
               // on the first BUSY edge, giving a one-cycle fast path.
               if (dbz_pend_q) begin
                  quotient_q    <= QSAT;
                  remainder_q   <= QSAT;
                  overflow_q    <= 1'b0;
                  div_by_zero_q <= 1'b1;
                  out_valid_q   <= 1'b1;
                  state_q       <= DONE;
               end else if (ovf_pend_q) begin
                  quotient_q    <= QSAT;
                  remainder_q   <= '0;
                  overflow_q    <= 1'b1;
                  div_by_zero_q <= 1'b0;
                  out_valid_q   <= 1'b1;
                  state_q       <= DONE;
               end else begin
                  r_q   <= step_r_next[DIVISOR_W-1:0];
                  q_q   <= q_d;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(STEPS - 1)) begin
                     quotient_q    <= q_d;
                     remainder_q   <= step_r_next[DIVISOR_W-1:0];
                     overflow_q    <= 1'b0;
                     div_by_zero_q <= 1'b0;
                     out_valid_q   <= 1'b1;
                     state_q       <= DONE;
                  end
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = out_valid_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign overflow    = overflow_q;
   assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_div16u8_seq_wrapper.sv
// -----------------------------------------------------------------------------
// tb_div16u8_seq_wrapper
// Scoreboard bench for the sequential 16/8 divider: expected results are
// queued when operands are driven and compared when out_valid appears.
// -----------------------------------------------------------------------------
module tb_div16u8_seq_wrapper;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  quotient;
   logic [7:0]  remainder;
   logic        overflow;
   logic        div_by_zero;

   div16u8_seq_wrapper dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] q;
      logic [7:0] r;
      logic       ovf;
      logic       dbz;
      logic [7:0] lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference behaviour written from the arithmetic definition.
   function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
      exp_t e;
      int   ai;
      int   bi;
      ai = int'(a);
      bi = int'(b);
      if (bi == 0) begin
         e = '{q: 8'hFF, r: 8'hFF, ovf: 1'b0, dbz: 1'b1, lat: 8'd1};
      end else if ((ai / 256) >= bi) begin
         e = '{q: 8'hFF, r: 8'h00, ovf: 1'b1, dbz: 1'b0, lat: 8'd1};
      end else begin
         e.q   = 8'(ai / bi);
         e.r   = 8'(ai % bi);
         e.ovf = 1'b0;
         e.dbz = 1'b0;
         e.lat = 8'd8;
      end
      return e;
   endfunction

   // Drive one operation, wait for the result, compare against the queue
   // head, optionally stall out_ready for 'hold' cycles, then consume.
   task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                        input exp_t e_push, input int hold, input string name);
      exp_t e;
      int   lat;
      @(negedge clk);
      chk({name, " in_ready"}, 32'(in_ready), 32'd1);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      sb_q.push_back(e_push);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      e = sb_q.pop_front();
      if (!out_valid) begin
         chk({name, " timeout"}, 32'd0, 32'd1);
         return;
      end
      $display("[TB] %s: %04h / %02h -> q=%02h r=%02h ovf=%0d dbz=%0d lat=%0d",
               name, a, b, quotient, remainder, overflow, div_by_zero, lat);
      chk({name, " latency"}, 32'(lat), 32'(e.lat));
      chk({name, " quotient"}, 32'(quotient), 32'(e.q));
      chk({name, " remainder"}, 32'(remainder), 32'(e.r));
      chk({name, " overflow"}, 32'(overflow), 32'(e.ovf));
      chk({name, " div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
      for (int i = 0; i < hold; i++) begin
         dividend = 16'h0001;
         divisor  = 8'h01;
         in_valid = 1'b1;
         @(negedge clk);
         chk({name, " hold out_valid"}, 32'(out_valid), 32'd1);
         chk({name, " hold in_ready"}, 32'(in_ready), 32'd0);
         chk({name, " hold quotient"}, 32'(quotient), 32'(e.q));
         chk({name, " hold remainder"}, 32'(remainder), 32'(e.r));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, " consumed out_valid"}, 32'(out_valid), 32'd0);
      chk({name, " consumed in_ready"}, 32'(in_ready), 32'd1);
      chk({name, " quotient kept"}, 32'(quotient), 32'(e.q));
   endtask

   initial begin
      exp_t        e;
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic [15:0] prod;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      @(negedge clk);
      @(negedge clk);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset quotient", 32'(quotient), 32'd0);
      chk("reset remainder", 32'(remainder), 32'd0);
      chk("reset flags", 32'({overflow, div_by_zero}), 32'd0);
      rst = 1'b0;

      do_op(16'h3039, 8'h7B, model(16'h3039, 8'h7B), 0, "12345/123");
      do_op(16'hFE01, 8'hFF, model(16'hFE01, 8'hFF), 0, "FE01/FF");
      do_op(16'h0000, 8'h01, model(16'h0000, 8'h01), 0, "0000/01");
      do_op(16'h1000, 8'h10, model(16'h1000, 8'h10), 0, "overflow");
      do_op(16'h1234, 8'h00, model(16'h1234, 8'h00), 0, "div0");
      do_op(16'h0064, 8'h07, model(16'h0064, 8'h07), 5, "backpressure");

      // Abort a division in its 4th BUSY cycle.
      @(negedge clk);
      dividend = 16'h3039;
      divisor  = 8'h7B;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort out_valid", 32'(out_valid), 32'd0);
      chk("abort in_ready", 32'(in_ready), 32'd1);
      chk("abort quotient", 32'(quotient), 32'd0);
      chk("abort remainder", 32'(remainder), 32'd0);
      chk("abort flags", 32'({overflow, div_by_zero}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post-abort out_valid", 32'(out_valid), 32'd0);
      do_op(16'h00FF, 8'h10, model(16'h00FF, 8'h10), 0, "after abort");

      // Round trip: product of two bytes divided by the nonzero factor.
      for (int i = 0; i < 1000; i++) begin
         ra   = 8'($urandom_range(1, 255));
         rb   = 8'($urandom_range(0, 255));
         prod = 16'(ra) * 16'(rb);
         e    = '{q: rb, r: 8'h00, ovf: 1'b0, dbz: 1'b0, lat: 8'd8};
         do_op(prod, ra, e, 0, $sformatf("roundtrip %0d*%0d", ra, rb));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
